// File: rtl/bp_cfg_reg_bank.sv
// bp_cfg_reg_bank: per-core configuration register bank behind a single
// command/response port. Local registers answer in one cycle. Offsets
// 'h8000-'h8fff are forwarded to an external ucode memory port.
module bp_cfg_reg_bank #(
    parameter int                       num_core_p    = 4,
    parameter int                       addr_width_p  = 20,
    parameter int                       data_width_p  = 64,
    parameter int                       vaddr_width_p = 39,
    parameter logic [vaddr_width_p-1:0] reset_pc_p    = vaddr_width_p'(32'h8000_0000)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  cmd_v_i,
    input  logic                                  cmd_w_i,
    input  logic [addr_width_p-1:0]               cmd_addr_i,
    input  logic [data_width_p-1:0]               cmd_data_i,
    output logic                                  cmd_ready_o,
    output logic                                  resp_v_o,
    output logic [data_width_p-1:0]               resp_data_o,
    output logic                                  resp_err_o,
    input  logic                                  resp_yumi_i,
    output logic [num_core_p-1:0]                 core_reset_o,
    output logic [num_core_p-1:0]                 freeze_o,
    output logic [num_core_p*vaddr_width_p-1:0]   npc_o,
    output logic [2*num_core_p-1:0]               icache_mode_o,
    output logic [2*num_core_p-1:0]               dcache_mode_o,
    output logic                                  cce_mode_o,
    output logic                                  ucode_v_o,
    output logic                                  ucode_w_o,
    output logic [11:0]                           ucode_addr_o,
    output logic [data_width_p-1:0]               ucode_data_o,
    input  logic                                  ucode_ready_i,
    input  logic                                  ucode_v_i,
    input  logic [data_width_p-1:0]               ucode_data_i
);

    localparam int sel_width_lp = addr_width_p - 16;

    localparam logic [15:0] off_reset_lp  = 16'h0001;
    localparam logic [15:0] off_freeze_lp = 16'h0002;
    localparam logic [15:0] off_icache_lp = 16'h0022;
    localparam logic [15:0] off_npc_lp    = 16'h0040;
    localparam logic [15:0] off_dcache_lp = 16'h0043;
    localparam logic [15:0] off_cce_lp    = 16'h0081;

    typedef enum logic [1:0] {
        ST_READY      = 2'd0,
        ST_UCODE_REQ  = 2'd1,
        ST_UCODE_WAIT = 2'd2,
        ST_RESP       = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FLD_NONE   = 3'd0,
        FLD_RESET  = 3'd1,
        FLD_FREEZE = 3'd2,
        FLD_ICACHE = 3'd3,
        FLD_NPC    = 3'd4,
        FLD_DCACHE = 3'd5,
        FLD_CCE    = 3'd6
    } field_e;

    // Control and response state
    state_e                    state_r, state_next_s;
    logic [data_width_p-1:0]   resp_data_r, resp_data_next_s;
    logic                      resp_err_r, resp_err_next_s;
    logic [11:0]               ucode_addr_r, ucode_addr_next_s;
    logic                      ucode_w_r, ucode_w_next_s;
    logic [data_width_p-1:0]   ucode_data_r, ucode_data_next_s;

    // Configuration registers
    logic [num_core_p-1:0]     core_reset_r;
    logic [num_core_p-1:0]     freeze_r;
    logic [vaddr_width_p-1:0]  npc_r         [num_core_p];
    logic [1:0]                icache_mode_r [num_core_p];
    logic [1:0]                dcache_mode_r [num_core_p];
    logic                      cce_mode_r;

    // Command decode
    logic [15:0]               offset_s;
    logic [sel_width_lp-1:0]   sel_s;
    logic                      bcast_s;
    logic                      is_ucode_s;
    field_e                    field_s;
    logic [num_core_p-1:0]     core_hit_s;
    logic                      core_ok_s;
    logic [num_core_p-1:0]     tgt_mask_s;
    logic                      cmd_err_s;
    logic [data_width_p-1:0]   core_val_s;
    logic [data_width_p-1:0]   rd_data_s;

    // Register write strobes, one bit per core
    logic [num_core_p-1:0]     reset_we_s;
    logic [num_core_p-1:0]     freeze_we_s;
    logic [num_core_p-1:0]     icache_we_s;
    logic [num_core_p-1:0]     npc_we_s;
    logic [num_core_p-1:0]     dcache_we_s;
    logic                      cce_we_s;

    // Decode offset/select into a target field, target core mask, error flag and read value
    always_comb begin
        offset_s   = cmd_addr_i[15:0];
        sel_s      = cmd_addr_i[addr_width_p-1:16];
        bcast_s    = &sel_s;
        is_ucode_s = (offset_s[15:12] == 4'h8);

        case (offset_s)
            off_reset_lp:  field_s = FLD_RESET;
            off_freeze_lp: field_s = FLD_FREEZE;
            off_icache_lp: field_s = FLD_ICACHE;
            off_npc_lp:    field_s = FLD_NPC;
            off_dcache_lp: field_s = FLD_DCACHE;
            off_cce_lp:    field_s = FLD_CCE;
            default:       field_s = FLD_NONE;
        endcase

        core_hit_s = '0;
        for (int i = 0; i < num_core_p; i++) begin
            core_hit_s[i] = (sel_s == sel_width_lp'(i));
        end
        core_ok_s = |core_hit_s;

        // Broadcast only fans out writes; a broadcast read has no single source
        if (core_ok_s) begin
            tgt_mask_s = core_hit_s;
        end else if (bcast_s && cmd_w_i) begin
            tgt_mask_s = '1;
        end else begin
            tgt_mask_s = '0;
        end

        // cce_mode and ucode are global: the select field is don't-care for them
        if (is_ucode_s || (field_s == FLD_CCE)) begin
            cmd_err_s = 1'b0;
        end else if (field_s == FLD_NONE) begin
            cmd_err_s = 1'b1;
        end else begin
            cmd_err_s = ~|tgt_mask_s;
        end

        rd_data_s  = '0;
        core_val_s = '0;
        for (int i = 0; i < num_core_p; i++) begin
            core_val_s = '0;
            case (field_s)
                FLD_RESET:  core_val_s[0]                 = core_reset_r[i];
                FLD_FREEZE: core_val_s[0]                 = freeze_r[i];
                FLD_ICACHE: core_val_s[1:0]               = icache_mode_r[i];
                FLD_NPC:    core_val_s[vaddr_width_p-1:0] = npc_r[i];
                FLD_DCACHE: core_val_s[1:0]               = dcache_mode_r[i];
                default:    core_val_s                    = '0;
            endcase
            rd_data_s = rd_data_s | ({data_width_p{core_hit_s[i]}} & core_val_s);
        end
        rd_data_s[0] = rd_data_s[0] | ((field_s == FLD_CCE) & cce_mode_r);
    end

    // Next-state, response capture and register write strobes
    always_comb begin
        state_next_s      = state_r;
        resp_data_next_s  = resp_data_r;
        resp_err_next_s   = resp_err_r;
        ucode_addr_next_s = ucode_addr_r;
        ucode_w_next_s    = ucode_w_r;
        ucode_data_next_s = ucode_data_r;
        reset_we_s        = '0;
        freeze_we_s       = '0;
        icache_we_s       = '0;
        npc_we_s          = '0;
        dcache_we_s       = '0;
        cce_we_s          = 1'b0;

        case (state_r)
            ST_READY: begin
                if (cmd_v_i) begin
                    if (is_ucode_s) begin
                        state_next_s      = ST_UCODE_REQ;
                        ucode_addr_next_s = offset_s[11:0];
                        ucode_w_next_s    = cmd_w_i;
                        ucode_data_next_s = cmd_data_i;
                        resp_data_next_s  = '0;
                        resp_err_next_s   = 1'b0;
                    end else begin
                        state_next_s    = ST_RESP;
                        resp_err_next_s = cmd_err_s;
                        if (cmd_err_s) begin
                            resp_data_next_s = '0;
                        end else if (cmd_w_i) begin
                            resp_data_next_s = '0;
                            case (field_s)
                                FLD_RESET:  reset_we_s  = tgt_mask_s;
                                FLD_FREEZE: freeze_we_s = tgt_mask_s;
                                FLD_ICACHE: icache_we_s = tgt_mask_s;
                                FLD_NPC:    npc_we_s    = tgt_mask_s;
                                FLD_DCACHE: dcache_we_s = tgt_mask_s;
                                FLD_CCE:    cce_we_s    = 1'b1;
                                default:    cce_we_s    = 1'b0;
                            endcase
                        end else begin
                            resp_data_next_s = rd_data_s;
                        end
                    end
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_UCODE_REQ: begin
                if (ucode_ready_i) begin
                    if (ucode_w_r) begin
                        state_next_s     = ST_RESP;
                        resp_data_next_s = '0;
                    end else begin
                        state_next_s = ST_UCODE_WAIT;
                    end
                end else begin
                    state_next_s = ST_UCODE_REQ;
                end
            end
            ST_UCODE_WAIT: begin
                if (ucode_v_i) begin
                    state_next_s     = ST_RESP;
                    resp_data_next_s = ucode_data_i;
                end else begin
                    state_next_s = ST_UCODE_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_yumi_i) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_READY;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_READY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Response payload and outgoing ucode request fields
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
            ucode_addr_r <= 12'h000;
            ucode_w_r    <= 1'b0;
            ucode_data_r <= '0;
        end else begin
            resp_data_r  <= resp_data_next_s;
            resp_err_r   <= resp_err_next_s;
            ucode_addr_r <= ucode_addr_next_s;
            ucode_w_r    <= ucode_w_next_s;
            ucode_data_r <= ucode_data_next_s;
        end
    end

    // Configuration registers; cores come out of reset held in reset and frozen
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            core_reset_r <= '1;
            freeze_r     <= '1;
            cce_mode_r   <= 1'b0;
            for (int i = 0; i < num_core_p; i++) begin
                npc_r[i]         <= reset_pc_p;
                icache_mode_r[i] <= 2'b00;
                dcache_mode_r[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < num_core_p; i++) begin
                if (reset_we_s[i])  core_reset_r[i]  <= cmd_data_i[0];
                if (freeze_we_s[i]) freeze_r[i]      <= cmd_data_i[0];
                if (icache_we_s[i]) icache_mode_r[i] <= cmd_data_i[1:0];
                if (npc_we_s[i])    npc_r[i]         <= cmd_data_i[vaddr_width_p-1:0];
                if (dcache_we_s[i]) dcache_mode_r[i] <= cmd_data_i[1:0];
            end
            if (cce_we_s) cce_mode_r <= cmd_data_i[0];
        end
    end

    // Handshake outputs decode straight from the state flop, so ucode_v_o and
    // resp_v_o are mutually exclusive by construction
    assign cmd_ready_o  = (state_r == ST_READY);
    assign resp_v_o     = (state_r == ST_RESP);
    assign ucode_v_o    = (state_r == ST_UCODE_REQ);
    assign resp_data_o  = resp_data_r;
    assign resp_err_o   = resp_err_r;
    assign ucode_w_o    = ucode_w_r;
    assign ucode_addr_o = ucode_addr_r;
    assign ucode_data_o = ucode_data_r;
    assign core_reset_o = core_reset_r;
    assign freeze_o     = freeze_r;
    assign cce_mode_o   = cce_mode_r;

    for (genvar g = 0; g < num_core_p; g++) begin : g_core_out
        assign npc_o[g*vaddr_width_p +: vaddr_width_p] = npc_r[g];
        assign icache_mode_o[2*g +: 2]                 = icache_mode_r[g];
        assign dcache_mode_o[2*g +: 2]                 = dcache_mode_r[g];
    end

endmodule
